// File: rtl/swap_pkg.sv
// Shared definitions for the swap engine: mode encoding, widths and FIFO depth.
package swap_pkg;

    localparam int MODE_W     = 3;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [MODE_W-1:0] {
        PASS    = 3'd0,
        NIBSWAP = 3'd1,
        BYTEREV = 3'd2,
        BITREV  = 3'd3,
        ROTL    = 3'd4
    } mode_t;

    // Codes above ROTL are reserved; they pass data through but raise mode_err.
    function automatic logic mode_is_legal(input logic [MODE_W-1:0] m);
        return m <= ROTL;
    endfunction

endpackage

// File: rtl/swap_core.sv
// Combinational permutation unit: selects one of the bit/nibble/byte shuffles.
module swap_core
    import swap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ROT_W  = $clog2(DATA_W/4)
) (
    input  logic [MODE_W-1:0] mode,
    input  logic [ROT_W-1:0]  rot,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] rot_data;

    // Log-depth nibble rotator: stage b rotates by 4*2^b bits when rot[b] is set.
    always_comb begin
        rot_data = data;
        for (int b = 0; b < ROT_W; b++) begin
            if (rot[b]) begin
                rot_data = (rot_data << ((4 << b) % DATA_W))
                         | (rot_data >> (DATA_W - ((4 << b) % DATA_W)));
            end
        end
    end

    // Mode select; reserved codes fall through to pass-through.
    always_comb begin
        result = data;
        case (mode)
            NIBSWAP: begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    result[i*8 +: 8] = {data[i*8 +: 4], data[i*8+4 +: 4]};
                end
            end
            BYTEREV: begin
                for (int i = 0; i < DATA_W/8; i++) begin
                    result[i*8 +: 8] = data[(DATA_W/8-1-i)*8 +: 8];
                end
            end
            BITREV: begin
                for (int i = 0; i < DATA_W; i++) begin
                    result[i] = data[DATA_W-1-i];
                end
            end
            ROTL:    result = rot_data;
            default: result = data;
        endcase
    end

endmodule

// File: rtl/swap_engine.sv
// Streaming permutation engine: permutes each accepted word into a 2-entry
// output FIFO, counts accepted words and flags reserved modes.
module swap_engine
    import swap_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    input  logic [MODE_W-1:0]              in_mode,
    input  logic [$clog2(DATA_W/4)-1:0]    in_rot,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [CNT_W-1:0]               word_cnt,
    output logic                           mode_err
);

    logic [DATA_W-1:0] perm;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [1:0]        count;
    logic              wr_ptr;
    logic              rd_ptr;
    logic              accept;
    logic              deliver;

    swap_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .mode   (in_mode),
        .rot    (in_rot),
        .data   (in_data),
        .result (perm)
    );

    // in_ready comes only from registered occupancy, never from out_ready.
    assign in_ready  = (count < 2'(FIFO_DEPTH));
    assign out_valid = (count != 2'd0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    // FIFO storage; contents need no reset because out_data is gated by out_valid.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr] <= perm;
        end
    end

    // Occupancy, pointers, word counter and sticky mode error.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            word_cnt <= '0;
            mode_err <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr   <= ~wr_ptr;
                word_cnt <= word_cnt + 1'b1;
                if (!mode_is_legal(in_mode)) begin
                    mode_err <= 1'b1;
                end
            end
            if (deliver) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({accept, deliver})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_swap_engine.sv
// Directed bench for swap_engine (DATA_W=32, CNT_W=4).
module tb_swap_engine;
    import swap_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_mode;
    logic [2:0]  in_rot;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  word_cnt;
    logic        mode_err;

    int n_cmp = 0;
    int n_err = 0;

    swap_engine #(
        .DATA_W (32),
        .CNT_W  (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .word_cnt  (word_cnt),
        .mode_err  (mode_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one word, check it one cycle later, then drain it.
    task automatic xfer(input string tag, input logic [2:0] m, input logic [2:0] r,
                        input logic [31:0] d, input logic [31:0] exp);
        in_valid = 1'b1;
        in_mode  = m;
        in_rot   = r;
        in_data  = d;
        step();
        in_valid = 1'b0;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_data"}, out_data, exp);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_mode   = '0;
        in_rot    = '0;
        out_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_mode_err", 32'(mode_err), 32'd0);

        // Mode vectors
        xfer("pass",    PASS,    3'd0, 32'hDEADBEEF, 32'hDEADBEEF);
        xfer("nibswap", NIBSWAP, 3'd0, 32'h12345678, 32'h21436587);
        xfer("byterev", BYTEREV, 3'd0, 32'h12345678, 32'h78563412);
        xfer("bitrev",  BITREV,  3'd0, 32'h00000001, 32'h80000000);
        xfer("rotl1",   ROTL,    3'd1, 32'h12345678, 32'h23456781);
        xfer("rotl0",   ROTL,    3'd0, 32'h12345678, 32'h12345678);
        xfer("rotl7",   ROTL,    3'd7, 32'h12345678, 32'h81234567);
        chk("mode_err_clean", 32'(mode_err), 32'd0);
        xfer("mode6",   3'd6,    3'd0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        chk("mode_err_set", 32'(mode_err), 32'd1);
        chk("cnt_after8", 32'(word_cnt), 32'd8);

        // Backpressure: three back-to-back words with out_ready low
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("bp_mode_err_clr", 32'(mode_err), 32'd0);
        in_valid = 1'b1; in_mode = PASS; in_rot = 3'd0; in_data = 32'h11111111;
        step();
        chk("bp_ready_after1", 32'(in_ready), 32'd1);
        in_mode = NIBSWAP; in_data = 32'h12345678;
        step();
        chk("bp_ready_after2", 32'(in_ready), 32'd0);
        in_mode = BYTEREV; in_data = 32'hAABBCCDD;
        step();
        chk("bp_stall_ready", 32'(in_ready), 32'd0);
        chk("bp_stall_cnt", 32'(word_cnt), 32'd2);
        chk("bp_hold_head", out_data, 32'h11111111);
        out_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(in_ready), 32'd1);
        chk("bp_second", out_data, 32'h21436587);
        step();
        in_valid = 1'b0;
        chk("bp_third", out_data, 32'hDDCCBBAA);
        chk("bp_cnt3", 32'(word_cnt), 32'd3);
        step();
        chk("bp_empty", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Illegal mode then reset mid-stream with two entries held
        in_valid = 1'b1; in_mode = 3'd6; in_data = 32'hA5A5A5A5;
        step();
        chk("ill_data", out_data, 32'hA5A5A5A5);
        chk("ill_mode_err", 32'(mode_err), 32'd1);
        in_mode = PASS; in_data = 32'h55AA55AA;
        step();
        chk("mid_full", 32'(in_ready), 32'd0);
        reset = 1'b1; out_ready = 1'b1;
        step();
        chk("mid_out_valid", 32'(out_valid), 32'd0);
        chk("mid_out_data", out_data, 32'd0);
        chk("mid_word_cnt", 32'(word_cnt), 32'd0);
        chk("mid_mode_err", 32'(mode_err), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        step();
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_nodata", 32'(out_valid), 32'd0);

        // Counter wrap: 17 words streamed with the consumer always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = PASS;
        for (int i = 0; i < 17; i++) begin
            in_data = 32'(i);
            step();
            if (i == 15) chk("wrap_at16", 32'(word_cnt), 32'd0);
        end
        in_valid = 1'b0;
        chk("wrap_cnt17", 32'(word_cnt), 32'd1);
        chk("wrap_last", out_data, 32'd16);
        step();
        chk("wrap_drained", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/swap_engine.md
SWAP_ENGINE -- requirements
Module: swap_engine

Interface
REQ-001 Parameter DATA_W, default 32, meaning data width in bits; SHALL be a multiple of 8 and at least 8.
REQ-002 Parameter CNT_W, default 16, meaning width of the accepted-word counter.
REQ-003 Port clk  input  1  meaning sole clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  meaning synchronous, active-high reset.
REQ-005 Port in_valid  input  1  meaning the producer presents a word.
REQ-006 Port in_ready  output  1  meaning the engine can accept a word.
REQ-007 Port in_data  input  DATA_W  meaning the word to permute.
REQ-008 Port in_mode  input  3  meaning the permutation for this word, sampled with in_data.
REQ-009 Port in_rot  input  $clog2(DATA_W/4)  meaning the nibble rotate amount, used only in ROTL mode.
REQ-010 Port out_valid  output  1  meaning a result is presented.
REQ-011 Port out_ready  input  1  meaning the consumer accepts the result.
REQ-012 Port out_data  output  DATA_W  meaning the permuted word.
REQ-013 Port word_cnt  output  CNT_W  meaning the count of accepted words.
REQ-014 Port mode_err  output  1  meaning a sticky flag that an illegal mode was accepted.

Function
REQ-015 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; a word SHALL be delivered on a rising edge where out_valid and out_ready are both 1.
REQ-016 Modes SHALL be:
- 0 PASS: out = in.
- 1 NIBSWAP: the two nibbles of every byte are exchanged.
- 2 BYTEREV: byte order is reversed.
- 3 BITREV: bit i maps to bit DATA_W-1-i.
- 4 ROTL: rotate left by 4*in_rot bits.
REQ-017 Modes 5-7 SHALL be processed as PASS and SHALL set mode_err on acceptance; mode_err SHALL clear only on reset.
REQ-018 The permutation SHALL be computed on the accepted word, and the result SHALL be written into a 2-entry output FIFO in the same edge.
REQ-019 Latency: a word accepted at edge N into an empty FIFO SHALL have out_valid=1 with its result from cycle N+1.
REQ-020 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries, and SHALL depend on registered state only (no combinational path from out_ready).
REQ-021 A simultaneous accept and deliver with 1 entry held SHALL keep occupancy at 1; with 0 entries held, occupancy SHALL become 1 (no bypass).
REQ-022 When full, a delivery SHALL free one slot, and in_ready SHALL return to 1 the following cycle.
REQ-023 Delivery order SHALL equal acceptance order; no word SHALL be dropped or duplicated.
REQ-024 out_valid SHALL be 1 exactly when occupancy is greater than 0; out_data SHALL be the head entry when out_valid=1, and 0 otherwise.
REQ-025 out_data SHALL be held stable while out_valid=1 and out_ready=0.
REQ-026 word_cnt SHALL increment by 1 per accepted word and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-027 While reset=1 at a rising edge, the following SHALL occur, overriding any simultaneous handshake:
- FIFO occupancy set to 0, so out_valid=0 and out_data=0.
- word_cnt set to 0.
- mode_err set to 0.
- in_ready set to 1 from the first cycle after reset deasserts.
REQ-028 A reset applied mid-stream SHALL discard all held words; no discarded word SHALL appear after reset.

Structure
REQ-029 A shared package swap_pkg SHALL hold:
- the mode enum (PASS, NIBSWAP, BYTEREV, BITREV, ROTL);
- the mode width constant;
- the FIFO depth constant 2.
REQ-030 The permutation SHALL be a combinational sub-module swap_core, parametrised by DATA_W; the FIFO, counter and flag logic SHALL reside in swap_engine.

Verification (DATA_W=32)
REQ-031 The bench SHALL cover NIBSWAP: 0x12345678 -> 0x21436587 with out_valid high one cycle after acceptance.
REQ-032 The bench SHALL cover BYTEREV and BITREV:
- BYTEREV 0x12345678 -> 0x78563412.
- BITREV 0x00000001 -> 0x80000000.
REQ-033 The bench SHALL cover ROTL with in_rot=1: 0x12345678 -> 0x23456781; and in_rot=0 -> unchanged.
REQ-034 The bench SHALL cover backpressure:
- With out_ready=0, three back-to-back words SHALL cause in_ready to go low after the second; the third SHALL stall.
- Raising out_ready SHALL deliver all three in order, and word_cnt SHALL equal 3.
REQ-035 The bench SHALL cover an illegal mode and reset mid-stream:
- Mode 6 with 0xA5A5A5A5 -> output 0xA5A5A5A5 and mode_err=1.
- Reset asserted with 2 entries held -> out_valid=0, word_cnt=0, mode_err=0 on the next cycle.
REQ-036 The bench SHALL cover counter wrap: with CNT_W=4, 17 accepted words -> word_cnt=1.
